// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Brief    : Opcode map, FSM state type and flag packing shared by alu_seq.
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Flag vector ordering is {overflow, carry, zero, negative}.
    function automatic logic [3:0] pack_flags(input logic ovf, input logic cy,
                                              input logic is_zero, input logic msb);
        return {ovf, cy, is_zero, msb};
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// ============================================================================
// Module   : alu_core
// Brief    : Combinational datapath for every single-cycle opcode.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             overflow,
    output logic             carry,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic             slt;
    logic             sltu;
    logic [SHW-1:0]   shamt;

    assign sum     = {1'b0, a} + {1'b0, b};
    assign diff    = {1'b0, a} - {1'b0, b};
    assign add_ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
    assign sub_ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
    // Signed less-than must survive overflow of the subtraction.
    assign slt     = diff[MSB] ^ sub_ovf;
    assign sltu    = diff[WIDTH];
    assign shamt   = b[SHW-1:0];

    always_comb begin
        res      = '0;
        overflow = 1'b0;
        carry    = 1'b0;
        illegal  = 1'b0;
        case (op)
            OP_ADD: begin
                res      = sum[WIDTH-1:0];
                overflow = add_ovf;
                carry    = sum[WIDTH];
            end
            OP_SUB: begin
                res      = diff[WIDTH-1:0];
                overflow = sub_ovf;
                carry    = ~diff[WIDTH];
            end
            OP_XOR:  res = a ^ b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_SLL:  res = a << shamt;
            OP_SRL:  res = a >> shamt;
            OP_SRA:  res = $unsigned($signed(a) >>> shamt);
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, slt};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, sltu};
            // The product is produced by the sequencer, not here.
            OP_MUL:  res = '0;
            default: illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// Module   : alu_seq
// Brief    : Handshaked, registered ALU with an iterative shift-add multiplier.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             overflow,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             illegal
);

    localparam int             SHW       = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [3:0]       flags_q, flags_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0] core_res;
    logic             core_ovf;
    logic             core_cy;
    logic             core_ill;
    logic             slot_free;
    logic             accept;
    logic [WIDTH-1:0] acc_sum;
    logic             load_mul;
    logic [WIDTH-1:0] product;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op       (op),
        .a        (a),
        .b        (b),
        .res      (core_res),
        .overflow (core_ovf),
        .carry    (core_cy),
        .illegal  (core_ill)
    );

    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = (state_q == ST_IDLE) && slot_free;
    assign accept    = in_valid && in_ready;
    assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !out_ready;
        res_d       = res_q;
        flags_d     = flags_q;
        illegal_d   = illegal_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        load_mul    = 1'b0;
        product     = acc_sum;

        case (state_q)
            ST_IDLE: begin
                if (accept && op == OP_MUL) begin
                    // Multiplier bit 0 is folded into the accept edge so the
                    // remaining WIDTH-1 bits finish in WIDTH-1 MUL cycles.
                    state_d  = ST_MUL;
                    mcand_d  = a << 1;
                    mplier_d = b >> 1;
                    acc_d    = b[0] ? a : '0;
                    cnt_d    = SHW'(1);
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    res_d       = core_res;
                    flags_d     = pack_flags(core_ovf, core_cy, core_res == '0,
                                             core_res[WIDTH-1]);
                    illegal_d   = core_ill;
                end
            end
            ST_MUL: begin
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                acc_d    = acc_sum;
                cnt_d    = cnt_q + SHW'(1);
                if (cnt_q == LAST_ITER) begin
                    cnt_d = '0;
                    if (slot_free) begin
                        state_d  = ST_IDLE;
                        load_mul = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                product = acc_q;
                if (out_ready) begin
                    state_d  = ST_IDLE;
                    load_mul = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_mul) begin
            out_valid_d = 1'b1;
            res_d       = product;
            flags_d     = pack_flags(1'b0, 1'b0, product == '0, product[WIDTH-1]);
            illegal_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            flags_q     <= '0;
            illegal_q   <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
            illegal_q   <= illegal_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid                           = out_valid_q;
    assign res                                 = res_q;
    assign {overflow, carry, zero, negative}   = flags_q;
    assign illegal                             = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// Module   : tb_alu_seq
// Brief    : Scoreboard bench for alu_seq with a behavioural reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic        overflow, carry, zero, negative, illegal;

    int          total = 0;
    int          passed = 0;
    int          cyc = 0;
    bit          rnd_rdy = 0;
    bit          rdy_cmd = 0;
    bit          rec = 0;
    int          pop_cyc[$];
    logic [36:0] sb[$];

    alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .overflow  (overflow),
        .carry     (carry),
        .zero      (zero),
        .negative  (negative),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: {res, overflow, carry, zero, negative, illegal} from plain arithmetic.
    function automatic logic [36:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx = longint'($signed(x));
        longint      sy = longint'($signed(y));
        longint      sr;
        logic [63:0] ur;
        logic [31:0] r = '0;
        logic        ov = 0, cy = 0, il = 0;
        case (o)
            4'd1: begin
                sr = sx + sy; ur = 64'(x) + 64'(y); r = ur[31:0];
                ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
                cy = (ur >= 64'h1_0000_0000);
            end
            4'd2: begin
                sr = sx - sy; r = x - y;
                ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
                cy = (x >= y);
            end
            4'd3:  r = x ^ y;
            4'd4:  r = x & y;
            4'd5:  r = x | y;
            4'd6:  r = x << (y % 32);
            4'd7:  r = x >> (y % 32);
            4'd8:  r = $unsigned($signed(x) >>> (y % 32));
            4'd9:  r = (sx < sy) ? 32'd1 : 32'd0;
            4'd10: r = (x < y) ? 32'd1 : 32'd0;
            4'd11: begin ur = 64'(x) * 64'(y); r = ur[31:0]; end
            default: il = 1;
        endcase
        return {r, ov, cy, (r == 32'd0), r[31], il};
    endfunction

    // out_ready driver: random in the soak phase, commanded otherwise.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            out_ready = rnd_rdy ? ($urandom_range(0, 1) == 1) : rdy_cmd;
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks output hold.
    initial begin
        bit          hold_pv = 0;
        logic [36:0] hold_vec = '0;
        logic [36:0] now_vec;
        logic [36:0] exp_vec;
        forever begin
            @(negedge clk);
            now_vec = {res, overflow, carry, zero, negative, illegal};
            if (!rst_n) begin
                hold_pv = 0;
            end else begin
                if (hold_pv)
                    check("hold_stable", {27'd0, out_valid, now_vec}, {27'd0, 1'b1, hold_vec});
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_result", {27'd0, now_vec}, 64'hDEAD);
                    end else begin
                        exp_vec = sb.pop_front();
                        check("result", {27'd0, now_vec}, {27'd0, exp_vec});
                        if (rec) pop_cyc.push_back(cyc);
                    end
                end
                hold_pv  = out_valid && !out_ready;
                hold_vec = now_vec;
            end
        end
    end

    // All tasks start and end at posedge+1.
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        bit done = 0;
        in_valid = 1'b1; op = o; a = x; b = y;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(o, x, y));
                done = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) check("issue_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    function automatic logic [31:0] rnd_operand();
        logic [31:0] specials[5] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        int bad;
        int n;
        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs", {57'd0, out_valid, res == 32'd0, overflow, carry, zero, negative, illegal},
              {57'd0, 1'b0, 1'b1, 5'd0});
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Directed single-cycle ops
        rdy_cmd = 1;
        issue(4'd1, 32'h7FFF_FFFF, 32'd1);
        issue(4'd2, 32'd5, 32'd7);
        issue(4'd9, 32'h8000_0000, 32'd1);
        issue(4'd10, 32'h8000_0000, 32'd1);
        issue(4'd8, 32'h8000_0000, 32'h0000_0024);
        drain();

        // MUL latency
        issue(4'd11, 32'hFFFF_FFFF, 32'd3);
        bad = 0;
        for (int i = 1; i <= 31; i++) begin
            @(negedge clk);
            if (in_ready || out_valid) bad++;
        end
        check("mul_busy_cycles", 64'(bad), 64'd0);
        @(negedge clk);
        check("mul_done_cycle32", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        issue(4'd11, 32'h0001_0000, 32'h0001_0000);
        drain();

        // Backpressure
        rdy_cmd = 0;
        issue(4'd1, 32'd1, 32'd2);
        in_valid = 1'b1; op = 4'd1; a = 32'd5; b = 32'd5;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!out_valid || res != 32'd3 || in_ready) bad++;
            @(posedge clk); #1;
        end
        check("backpressure_hold", 64'(bad), 64'd0);
        rdy_cmd = 1;
        @(negedge clk);
        check("accept_on_retire", 64'(in_ready), 64'd1);
        if (in_ready) sb.push_back(model(4'd1, 32'd5, 32'd5));
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Streaming
        pop_cyc.delete();
        rec = 1;
        for (int i = 0; i < 8; i++)
            issue((i == 5) ? 4'hE : 4'($urandom_range(1, 10)), rnd_operand(), rnd_operand());
        drain();
        @(posedge clk); #1;
        rec = 0;
        check("stream_count", 64'(pop_cyc.size()), 64'd8);
        if (pop_cyc.size() == 8)
            check("stream_consecutive", 64'(pop_cyc[7] - pop_cyc[0]), 64'd7);

        // Randomised soak with random backpressure
        rnd_rdy = 1;
        for (int i = 0; i < 300; i++) begin
            issue(4'($urandom_range(0, 15)), rnd_operand(), rnd_operand());
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        rnd_rdy = 0;
        drain();

        // Asynchronous reset mid-MUL
        issue(4'd1, 32'h1234_5678, 32'd1);
        drain();
        issue(4'd11, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_clears", {62'd0, out_valid, res == 32'd0}, {62'd0, 1'b0, 1'b1});
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_midmul_reset", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        issue(4'd1, 32'd40, 32'd2);
        drain();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check("no_stale_product", 64'(n), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
